// File: rtl/d_write_buffer_pkg.sv
// Shared types and constants for the store write buffer and its address comparators.
package d_write_buffer_pkg;

  localparam int WB_DEPTH   = 4;
  localparam int WB_AW      = 16;
  localparam int WB_DW      = 16;
  localparam int WB_BLK_OFF = 4;

  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    CMP_WORD  = 1'b0,
    CMP_BLOCK = 1'b1
  } wb_cmp_e;

  function automatic logic addr_match(input logic [WB_AW-1:0] a,
                                      input logic [WB_AW-1:0] b,
                                      input wb_cmp_e          mode);
    if (mode == CMP_BLOCK) return a[WB_AW-1:WB_BLK_OFF] == b[WB_AW-1:WB_BLK_OFF];
    return a == b;
  endfunction

endpackage

// File: rtl/d_write_buffer_match.sv
// DEPTH-way comparator of a probe address against all valid buffer entries.
module wb_match
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  wb_entry_t [DEPTH-1:0] entries_i,
  input  logic [WB_AW-1:0]      addr_i,
  input  wb_cmp_e               mode_i,
  output logic                  hit_o,
  output logic [DEPTH-1:0]      onehot_o
);

  // Word mode yields at most one set bit because coalescing keeps addresses unique.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      onehot_o[i] = entries_i[i].valid && addr_match(entries_i[i].addr, addr_i, mode_i);
    end
  end

  assign hit_o = |onehot_o;

endmodule

// File: rtl/d_write_buffer.sv
// Store write buffer: coalescing circular FIFO draining one word per granted memory cycle.
module d_write_buffer
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WB_AW-1:0] wr_addr,
  input  logic [WB_DW-1:0] wr_data,
  output logic             wb_full,
  output logic             wb_empty,
  input  logic             mem_grant,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [WB_AW-1:0] mem_addr,
  output logic [WB_DW-1:0] mem_data,
  input  logic [WB_AW-1:0] chk_addr,
  output logic             chk_hit
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW:0]           head_q, head_d;
  logic [PW:0]           tail_q, tail_d;
  logic [PW:0]           count_q, count_d;

  logic [PW-1:0]         head_idx, tail_idx;
  logic                  pop, coalesce, alloc;
  logic [DEPTH-1:0]      word_vec, pop_mask, coal_vec;
  logic                  word_hit;
  logic [DEPTH-1:0]      blk_vec;

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];

  assign wb_full  = (count_q == (PW+1)'(DEPTH));
  assign wb_empty = (count_q == '0);

  wb_match #(.DEPTH(DEPTH)) u_coal_match (
    .entries_i (entries_q),
    .addr_i    (wr_addr),
    .mode_i    (CMP_WORD),
    .hit_o     (word_hit),
    .onehot_o  (word_vec)
  );

  wb_match #(.DEPTH(DEPTH)) u_chk_match (
    .entries_i (entries_q),
    .addr_i    (chk_addr),
    .mode_i    (CMP_BLOCK),
    .hit_o     (chk_hit),
    .onehot_o  (blk_vec)
  );

  assign pop      = mem_grant & ~wb_empty;
  assign mem_en   = pop;
  assign mem_wr   = pop;
  assign mem_addr = entries_q[head_idx].addr;
  assign mem_data = entries_q[head_idx].data;

  // The head leaving this cycle must not absorb a new store; it gets a fresh entry instead.
  assign pop_mask = pop ? (DEPTH'(1) << head_idx) : '0;
  assign coal_vec = word_vec & ~pop_mask;
  assign coalesce = wr_req & (|coal_vec);
  assign alloc    = wr_req & ~coalesce & (~wb_full | pop);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q + (PW+1)'(pop);
    tail_d    = tail_q + (PW+1)'(alloc);
    count_d   = count_q + (PW+1)'(alloc) - (PW+1)'(pop);

    if (pop) entries_d[head_idx].valid = 1'b0;

    if (coalesce) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (coal_vec[i]) entries_d[i].data = wr_data;
      end
    end else if (alloc) begin
      // When full and popping, tail aliases head; this write lands after the invalidate.
      entries_d[tail_idx] = '{valid: 1'b1, addr: wr_addr, data: wr_data};
    end
  end

  // NOTE: entry storage is reset too, so mem_addr/mem_data read zero out of reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule
